// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared widths and entry type for the instruction fetch unit
package rv_fetch_pkg;

  localparam int DEF_XLEN = 32;
  localparam int ILEN     = 32;
  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer with flush, count, full and empty
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];

  // Pointers and occupancy; flush empties the buffer ahead of any push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage has no reset; the head is only consumed while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, credit-limited imem requester and decode feeder
module instruction_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            is_jump_instr,
  input  logic [XLEN-1:0] jump_loc,
  input  logic            is_branch_instr,
  input  logic [XLEN-1:0] branch_loc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int            CW      = $clog2(FBUF_DEPTH + 1);
  localparam int            EW      = XLEN + ILEN;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FBUF_DEPTH);
  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_in_use;
  logic [CW-1:0]   w_fifo_count;
  logic [EW-1:0]   w_head;
  logic            w_redirect;
  logic            w_accept;
  logic            w_push;
  logic            w_rsp_dec;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  assign w_redirect = is_jump_instr | is_branch_instr;
  assign w_target   = (is_jump_instr ? jump_loc : branch_loc) & ALIGN;

  // Every request in flight owns a buffer slot, so responses never need back-pressure.
  assign w_in_use       = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid = !reset && !w_redirect && (w_in_use < DEPTH_W);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a reset can still arrive; the count must not wrap.
  assign w_rsp_dec = imem_rsp_valid && (r_outstanding != '0);
  assign w_push    = imem_rsp_valid && !w_redirect && (r_drop_cnt == '0);

  assign instr_valid = !w_fifo_empty;
  assign instr       = instr_valid ? w_head[ILEN-1:0] : '0;
  assign instr_pc    = instr_valid ? w_head[EW-1:ILEN] : '0;

  // Fetch PC: jumps to the redirect target, otherwise steps past each accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_pc <= RESET_PC;
    else if (w_redirect) r_pc <= w_target;
    else if (w_accept)   r_pc <= r_pc + XLEN'(PC_STEP);
  end

  // Label for the next kept response; realigned with the fetch stream on redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_rsp_pc <= RESET_PC;
    else if (w_redirect) r_rsp_pc <= w_target;
    else if (w_push)     r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
  end

  // Requests in flight, and how many of them belong to a squashed stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_dec);
      if (w_redirect)
        r_drop_cnt <= r_outstanding - CW'(w_rsp_dec);
      else if (imem_rsp_valid && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FBUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({r_rsp_pc, imem_rsp_data}),
    .pop       (instr_ready),
    .flush     (w_redirect),
    .head      (w_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
    r_outstanding <= CW'(FBUF_DEPTH));
  a_drop_bound: assert property (@(posedge clk) disable iff (reset)
    r_drop_cnt <= r_outstanding);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (w_push && w_fifo_full) |-> instr_ready);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench against a fetch-stream reference model
module tb_instruction_fetch_unit;
  import rv_fetch_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_jump_instr, is_branch_instr;
  logic [31:0] jump_loc, branch_loc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_instr, w_instr_pc;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FBUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .is_jump_instr(is_jump_instr), .jump_loc(jump_loc),
    .is_branch_instr(is_branch_instr), .branch_loc(branch_loc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC), .FBUF_DEPTH(2)) dut_w (
    .clk(clk), .reset(reset),
    .is_jump_instr(1'b0), .jump_loc(32'h0),
    .is_branch_instr(1'b0), .branch_loc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b0), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  int           n_vec, n_err, cyc, lat;
  bit           rdy_rand;
  logic         rdy_fixed;
  logic [31:0]  pend_addr[$];
  int           pend_due[$];
  logic [31:0]  req_got[$], req_exp[$];
  fetch_entry_t pop_got[$];
  logic [31:0]  pop_exp[$];
  logic [31:0]  m_req_pc, m_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: in-order responses a fixed number of cycles after acceptance.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Stream model: requests and delivered instructions walk +4 from the last redirect target.
  always @(negedge clk) begin
    if (reset) begin
      m_req_pc = 32'h0;
      m_pop_pc = 32'h0;
    end else begin
      if (is_jump_instr || is_branch_instr) begin
        m_req_pc = (is_jump_instr ? jump_loc : branch_loc) & 32'hFFFF_FFFC;
        m_pop_pc = m_req_pc;
      end else if (instr_valid && instr_ready) begin
        pop_got.push_back({instr_pc, instr});
        pop_exp.push_back(m_pop_pc);
        m_pop_pc += 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
        req_got.push_back(imem_req_addr);
        req_exp.push_back(m_req_pc);
        m_req_pc += 32'd4;
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
      end
      if (imem_rsp_valid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    pend_addr.delete(); pend_due.delete();
    req_got.delete(); req_exp.delete();
    pop_got.delete(); pop_exp.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    is_jump_instr = 1'b0; is_branch_instr = 1'b0;
    tick(1);
    clear_logs();
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    clear_logs();
    n_vec += 5;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", instr); end
    if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
    reset = 1'b0;
    #1;
    n_vec += 3;
    if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
    if (w_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_req_valid: got %b want 1", w_req_valid); end
    if (w_req_addr !== WRAP_PC) begin n_err++; $display("FAIL wrap_req_addr: got %h want %h", w_req_addr, WRAP_PC); end
  endtask

  task automatic test_stream();
    lat = 1; rdy_rand = 0; rdy_fixed = 1'b1; instr_ready = 1'b1;
    do_reset();
    tick(12);
    n_vec++;
    if (pop_got.size() < 3) begin
      n_err++; $display("FAIL seq_count: got %0d pops want >=3", pop_got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (pop_got[i].pc !== 32'(4 * i) || pop_got[i].instr !== mem_word(32'(4 * i))) begin
          n_err++;
          $display("FAIL seq_pop[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                   i, pop_got[i].pc, pop_got[i].instr, 32'(4 * i), mem_word(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; rdy_fixed = 1'b1; instr_ready = 1'b0;
    do_reset();
    tick(8);
    n_vec += 3;
    if (req_got.size() != 2) begin n_err++; $display("FAIL bp_req_count: got %0d want 2", req_got.size()); end
    else if (req_got[0] !== 32'h0 || req_got[1] !== 32'h4) begin
      n_err++; $display("FAIL bp_req_addr: got %h,%h want 0,4", req_got[0], req_got[1]);
    end
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_instr_valid: got %b want 1", instr_valid); end
    instr_ready = 1'b1;
    tick(6);
    n_vec += 2;
    if (pop_got.size() < 2 || pop_got[0].pc !== 32'h0 || pop_got[1].pc !== 32'h4) begin
      n_err++; $display("FAIL bp_pops: got %0d pops want pcs 0,4 first", pop_got.size());
    end
    if (req_got.size() < 3 || req_got[2] !== 32'h8) begin
      n_err++; $display("FAIL bp_resume: got %0d reqs want third at 8", req_got.size());
    end
  endtask

  task automatic test_branch_flush();
    lat = 3; rdy_fixed = 1'b1; instr_ready = 1'b1;
    do_reset();
    tick(2);
    is_branch_instr = 1'b1; branch_loc = 32'h100;
    #1;
    n_vec++;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL br_req_valid: got %b want 0", imem_req_valid); end
    tick(1);
    is_branch_instr = 1'b0;
    tick(14);
    n_vec += 3;
    if (req_got.size() < 3 || req_got[2] !== 32'h100) begin
      n_err++; $display("FAIL br_req_target: got %0d reqs want third at 100", req_got.size());
    end
    if (pop_got.size() < 2) begin
      n_err++; $display("FAIL br_pop_count: got %0d want >=2", pop_got.size());
    end else begin
      if (pop_got[0].pc !== 32'h100 || pop_got[0].instr !== mem_word(32'h100)) begin
        n_err++; $display("FAIL br_pop0: got pc=%h instr=%h want pc=100 instr=%h", pop_got[0].pc, pop_got[0].instr, mem_word(32'h100));
      end
      if (pop_got[1].pc !== 32'h104) begin
        n_err++; $display("FAIL br_pop1: got pc=%h want 104", pop_got[1].pc);
      end
    end
  endtask

  task automatic test_jump_priority();
    int n0, n1;
    lat = 2; rdy_fixed = 1'b1; instr_ready = 1'b1;
    do_reset();
    tick(3);
    is_jump_instr = 1'b1; jump_loc = 32'h200;
    is_branch_instr = 1'b1; branch_loc = 32'h300;
    #1;
    n_vec++;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL jp_req_valid: got %b want 0", imem_req_valid); end
    n0 = req_got.size();
    tick(1);
    is_jump_instr = 1'b0; is_branch_instr = 1'b0;
    tick(6);
    n_vec++;
    if (req_got.size() <= n0 || req_got[n0] !== 32'h200) begin
      n_err++; $display("FAIL jp_target: got %0d reqs want entry %0d at 200", req_got.size(), n0);
    end
    n1 = req_got.size();
    is_branch_instr = 1'b1; branch_loc = 32'h102;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL hold_req_valid[%0d]: got %b want 0", k, imem_req_valid); end
      tick(1);
    end
    is_branch_instr = 1'b0;
    tick(8);
    n_vec++;
    if (req_got.size() <= n1 || req_got[n1] !== 32'h100) begin
      n_err++; $display("FAIL jp_align: got %0d reqs want entry %0d at 100", req_got.size(), n1);
    end
  endtask

  task automatic test_wrap();
    int n0, p0;
    logic [31:0] want;
    lat = 1; rdy_fixed = 1'b1; instr_ready = 1'b1;
    do_reset();
    tick(1);
    is_jump_instr = 1'b1; jump_loc = WRAP_PC;
    n0 = req_got.size(); p0 = pop_got.size();
    tick(1);
    is_jump_instr = 1'b0;
    tick(12);
    for (int i = 0; i < 3; i++) begin
      want = WRAP_PC + 32'(4 * i);
      n_vec += 2;
      if (req_got.size() <= n0 + i || req_got[n0 + i] !== want) begin
        n_err++; $display("FAIL wrap_req[%0d]: got %0d reqs want addr %h", i, req_got.size(), want);
      end
      if (pop_got.size() <= p0 + i || pop_got[p0 + i].pc !== want || pop_got[p0 + i].instr !== mem_word(want)) begin
        n_err++; $display("FAIL wrap_pop[%0d]: got %0d pops want pc %h", i, pop_got.size(), want);
      end
    end
  endtask

  task automatic test_random();
    lat = int'($urandom_range(1, 4)); rdy_rand = 1; instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        is_jump_instr = 1'($urandom_range(0, 1));
        is_branch_instr = 1'($urandom_range(0, 1));
        jump_loc = $urandom(); branch_loc = $urandom();
      end else begin
        is_jump_instr = 1'b0; is_branch_instr = 1'b0;
      end
      tick(1);
    end
    is_jump_instr = 1'b0; is_branch_instr = 1'b0;
    rdy_rand = 0; rdy_fixed = 1'b1; instr_ready = 1'b1;
    tick(20);
    n_vec++;
    if (pop_got.size() < 50) begin n_err++; $display("FAIL rnd_count: got %0d pops want >=50", pop_got.size()); end
    foreach (pop_got[i]) begin
      n_vec++;
      if (pop_got[i].pc !== pop_exp[i] || pop_got[i].instr !== mem_word(pop_exp[i])) begin
        n_err++;
        $display("FAIL rnd_pop[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                 i, pop_got[i].pc, pop_got[i].instr, pop_exp[i], mem_word(pop_exp[i]));
      end
    end
    foreach (req_got[i]) begin
      n_vec++;
      if (req_got[i] !== req_exp[i]) begin
        n_err++; $display("FAIL rnd_req[%0d]: got %h want %h", i, req_got[i], req_exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] late[$];
    lat = 3; rdy_fixed = 1'b1; instr_ready = 1'b0;
    do_reset();
    tick(5);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    tick(1);
    n_vec++;
    if (instr_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid: got %b want 1", instr_valid); end
    late = pend_addr;
    rdy_fixed = 1'b0; imem_req_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_vec += 4;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ar_instr_valid: got %b want 0", instr_valid); end
    if (instr !== 32'h0) begin n_err++; $display("FAIL ar_instr: got %h want 0", instr); end
    if (instr_pc !== 32'h0) begin n_err++; $display("FAIL ar_instr_pc: got %h want 0", instr_pc); end
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL ar_req_valid: got %b want 0", imem_req_valid); end
    reset = 1'b0;
    m_req_pc = 32'h0; m_pop_pc = 32'h0;
    tick(6);
    n_vec++;
    if (late.size() == 0) begin
      n_err++; $display("FAIL ar_late: got 0 requests in flight want >=1");
    end else if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(late[0])) begin
      n_err++; $display("FAIL ar_late: got valid=%b pc=%h instr=%h want valid=1 pc=0 instr=%h",
                        instr_valid, instr_pc, instr, mem_word(late[0]));
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat = 1;
    rdy_rand = 0; rdy_fixed = 1'b1;
    reset = 1'b1;
    is_jump_instr = 1'b0; is_branch_instr = 1'b0;
    jump_loc = '0; branch_loc = '0;
    instr_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_flush();
    test_jump_priority();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
